// File: rtl/microseq_pkg.sv
// Shared encodings and helpers for the micro-op sequencer.
// Sequencing field lives in the low bits of every control word.
package microseq_pkg;

  localparam int unsigned SEQ_LSB = 0;
  localparam int unsigned SEQ_W   = 3;
  localparam int unsigned MAX_W   = 64;

  typedef enum logic [SEQ_W-1:0] {
    SeqEnd    = 3'd0,
    SeqNext   = 3'd1,
    SeqJump   = 3'd2,
    SeqCall   = 3'd3,
    SeqRet    = 3'd4,
    SeqBranch = 3'd5,
    SeqWait   = 3'd6,
    SeqRsvd   = 3'd7
  } seq_e;

  // Jump/call target occupies the top upc_w bits of a ctrl_w-wide control word.
  function automatic logic [MAX_W-1:0] target_field(input logic [MAX_W-1:0] ctrl,
                                                    input int unsigned ctrl_w,
                                                    input int unsigned upc_w);
    logic [MAX_W-1:0] mask;
    mask = (64'd1 << upc_w) - 64'd1;
    return (ctrl >> (ctrl_w - upc_w)) & mask;
  endfunction

endpackage

// File: rtl/microseq_stack.sv
// Bounded LIFO holding micro-PC return addresses.
// Storage and pointer only; overflow/underflow policy belongs to the caller.
module microseq_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [2**AW];
  logic [PW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full   = (ptr == PW'(DEPTH));
  assign empty  = (ptr == '0);
  assign wr_idx = AW'(ptr);
  assign rd_idx = AW'(ptr - PW'(1));
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Micro-op sequencer: label-ROM dispatch, jumps, branches, waits and call/return,
// presenting one registered control word per cycle to the _2a stage.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int unsigned CTRL_W      = 32,
  parameter int unsigned UPC_W       = 10,
  parameter int unsigned OP_W        = 8,
  parameter int unsigned MODE_W      = 1,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [MODE_W-1:0]        mode,
  input  logic [OP_W-1:0]          opcode,
  input  logic                     mc__stall,
  input  logic                     cond_in,
  output logic [MODE_W+OP_W-1:0]   label_addr,
  input  logic [UPC_W:0]           label_data,
  output logic [UPC_W-1:0]         ucode_addr,
  input  logic [CTRL_W-1:0]        ucode_data,
  output logic [CTRL_W-1:0]        mc__control_2a,
  output logic                     mc__more_2a,
  output logic [UPC_W-1:0]         mc__upc,
  output logic                     mc__illegal,
  output logic                     mc__err
);

  // op_q keeps the full op across stalls so a held JUMP/CALL still knows its target;
  // out_q is what the pipeline sees (bubbled while stalled).
  logic [CTRL_W-1:0] op_q;
  logic [CTRL_W-1:0] out_q;
  logic [UPC_W-1:0]  upc_q;
  logic              more_q;
  logic              illegal_q;
  logic              err_q;

  seq_e              seq;
  logic [UPC_W-1:0]  upc_inc;
  logic [UPC_W-1:0]  target;
  logic              label_valid;
  logic [UPC_W-1:0]  label_upc;
  logic [UPC_W-1:0]  next_upc;
  logic [CTRL_W-1:0] ctrl_next;
  logic [CTRL_W-1:0] bubble;
  logic              dispatch;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              stk_full;
  logic              stk_empty;
  logic [UPC_W-1:0]  stk_top;

  assign seq         = seq_e'(op_q[SEQ_LSB +: SEQ_W]);
  assign upc_inc     = upc_q + UPC_W'(1);
  assign target      = UPC_W'(target_field(MAX_W'(op_q), CTRL_W, UPC_W));
  assign label_valid = label_data[UPC_W];
  assign label_upc   = label_data[UPC_W-1:0];

  assign label_addr  = {mode, opcode};
  assign ucode_addr  = next_upc;

  always_comb begin
    dispatch = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    next_upc = upc_inc;
    case (seq)
      SeqNext:   next_upc = upc_inc;
      SeqJump:   next_upc = target;
      SeqCall: begin
        next_upc = target;
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      SeqRet: begin
        if (stk_empty) begin
          dispatch = 1'b1;
          err_set  = 1'b1;
        end else begin
          pop      = 1'b1;
          next_upc = stk_top;
        end
      end
      SeqBranch: next_upc = cond_in ? target : upc_inc;
      SeqWait:   next_upc = cond_in ? upc_inc : upc_q;
      default:   dispatch = 1'b1;
    endcase
    // Invalid label: hold upc and load an END op so the next cycle re-dispatches.
    if (dispatch) begin
      next_upc = label_valid ? label_upc : upc_q;
    end
    ctrl_next = (dispatch && !label_valid) ? '0 : ucode_data;
    bubble = '0;
    bubble[SEQ_LSB +: SEQ_W] = op_q[SEQ_LSB +: SEQ_W];
  end

  microseq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (UPC_W)
  ) u_stack (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push && !mc__stall),
    .pop   (pop && !mc__stall),
    .din   (upc_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q      <= '0;
      out_q     <= '0;
      upc_q     <= '0;
      more_q    <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (mc__stall) begin
      out_q     <= bubble;
      illegal_q <= 1'b0;
    end else begin
      op_q      <= ctrl_next;
      out_q     <= ctrl_next;
      upc_q     <= next_upc;
      more_q    <= (ctrl_next[SEQ_LSB +: SEQ_W] != SeqEnd);
      illegal_q <= dispatch && !label_valid;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mc__control_2a = out_q;
  assign mc__more_2a    = more_q;
  assign mc__upc        = upc_q;
  assign mc__illegal    = illegal_q;
  assign mc__err        = err_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: ROM models, per-cycle scoreboard of expected
// upc/control/flags, checked with immediate assertions one cycle after each step.
module tb_microsequencer;

  localparam int unsigned CTRL_W      = 32;
  localparam int unsigned UPC_W       = 10;
  localparam int unsigned OP_W        = 8;
  localparam int unsigned MODE_W      = 1;
  localparam int unsigned STACK_DEPTH = 4;

  localparam logic [2:0] S_END = 3'd0, S_NEXT = 3'd1, S_CALL = 3'd3, S_RET = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5, S_WAIT = 3'd6;

  logic                   clk = 1'b0;
  logic                   rst_b;
  logic [MODE_W-1:0]      mode;
  logic [OP_W-1:0]        opcode;
  logic                   mc__stall;
  logic                   cond_in;
  logic [MODE_W+OP_W-1:0] label_addr;
  logic [UPC_W:0]         label_data;
  logic [UPC_W-1:0]       ucode_addr;
  logic [CTRL_W-1:0]      ucode_data;
  logic [CTRL_W-1:0]      mc__control_2a;
  logic                   mc__more_2a;
  logic [UPC_W-1:0]       mc__upc;
  logic                   mc__illegal;
  logic                   mc__err;

  logic [UPC_W:0]         lrom [2**(MODE_W+OP_W)];
  logic [CTRL_W-1:0]      crom [2**UPC_W];

  typedef struct {
    logic [UPC_W-1:0]  upc;
    logic [CTRL_W-1:0] ctrl;
    logic              more;
    logic              illegal;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  assign label_data = lrom[label_addr];
  assign ucode_data = crom[ucode_addr];

  microsequencer #(
    .CTRL_W      (CTRL_W),
    .UPC_W       (UPC_W),
    .OP_W        (OP_W),
    .MODE_W      (MODE_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .mode           (mode),
    .opcode         (opcode),
    .mc__stall      (mc__stall),
    .cond_in        (cond_in),
    .label_addr     (label_addr),
    .label_data     (label_data),
    .ucode_addr     (ucode_addr),
    .ucode_data     (ucode_data),
    .mc__control_2a (mc__control_2a),
    .mc__more_2a    (mc__more_2a),
    .mc__upc        (mc__upc),
    .mc__illegal    (mc__illegal),
    .mc__err        (mc__err)
  );

  // Non-zero filler in the middle bits so bubbles are distinguishable from real ops.
  function automatic logic [31:0] mk(input logic [9:0] tgt, input logic [2:0] s);
    return {tgt, 19'h5A5A5 ^ {9'd0, tgt}, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".upc"}, {22'd0, mc__upc}, {22'd0, e.upc});
    chk({tag, ".ctrl"}, mc__control_2a, e.ctrl);
    chk({tag, ".more"}, {31'd0, mc__more_2a}, {31'd0, e.more});
    chk({tag, ".illegal"}, {31'd0, mc__illegal}, {31'd0, e.illegal});
    chk({tag, ".err"}, {31'd0, mc__err}, {31'd0, e.err});
  endtask

  task automatic push_zero();
    exp_t e;
    e.upc = '0; e.ctrl = '0; e.more = 1'b0; e.illegal = 1'b0; e.err = 1'b0;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, predict the state after the edge, then compare.
  task automatic step(input string tag, input logic stall_v, input logic cond_v,
                      input logic [9:0] e_upc, input logic e_ill, input logic e_err);
    exp_t e;
    mc__stall = stall_v;
    cond_in   = cond_v;
    e.upc     = e_upc;
    e.ctrl    = e_ill ? 32'd0 : (stall_v ? (crom[e_upc] & 32'h7) : crom[e_upc]);
    e.more    = (e.ctrl[2:0] != 3'd0);
    e.illegal = e_ill;
    e.err     = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst_b = 1'b0; mode = '0; opcode = 8'h12; mc__stall = 1'b0; cond_in = 1'b0;
    for (int i = 0; i < 2**(MODE_W+OP_W); i++) lrom[i] = '0;
    for (int i = 0; i < 2**UPC_W; i++) crom[i] = mk(10'h000, S_END);
    lrom[9'h012] = {1'b1, 10'h040};
    lrom[9'h020] = {1'b1, 10'h050};
    lrom[9'h030] = {1'b1, 10'h200};
    lrom[9'h040] = {1'b1, 10'h060};
    lrom[9'h041] = {1'b1, 10'h060};
    lrom[9'h050] = {1'b1, 10'h070};
    lrom[9'h060] = {1'b1, 10'h090};
    lrom[9'h112] = {1'b1, 10'h080};
    crom[10'h040] = mk(10'h000, S_NEXT);
    crom[10'h041] = mk(10'h000, S_NEXT);
    crom[10'h050] = mk(10'h100, S_CALL);
    crom[10'h100] = mk(10'h000, S_NEXT);
    crom[10'h101] = mk(10'h000, S_RET);
    crom[10'h200] = mk(10'h210, S_CALL);
    crom[10'h210] = mk(10'h220, S_CALL);
    crom[10'h220] = mk(10'h230, S_CALL);
    crom[10'h230] = mk(10'h240, S_CALL);
    crom[10'h240] = mk(10'h250, S_CALL);
    crom[10'h250] = mk(10'h000, S_RET);
    crom[10'h231] = mk(10'h000, S_RET);
    crom[10'h221] = mk(10'h000, S_RET);
    crom[10'h211] = mk(10'h000, S_RET);
    crom[10'h060] = mk(10'h068, S_BRANCH);
    crom[10'h070] = mk(10'h000, S_WAIT);
    crom[10'h080] = mk(10'h000, S_NEXT);
    crom[10'h081] = mk(10'h000, S_NEXT);
    crom[10'h082] = mk(10'h000, S_NEXT);
    crom[10'h090] = mk(10'h000, S_RET);

    repeat (2) @(posedge clk);
    #1;
    push_zero();
    check_out("reset");
    rst_b = 1'b1;

    // Basic dispatch and NEXT run; next opcode sampled while END at 0x042.
    step("b0", 0, 0, 10'h040, 0, 0);
    step("b1", 0, 0, 10'h041, 0, 0);
    step("b2", 0, 0, 10'h042, 0, 0);
    opcode = 8'h20;
    #1;
    chk("uaddr_dispatch", {22'd0, ucode_addr}, 32'h050);

    // Call / return.
    step("c0", 0, 0, 10'h050, 0, 0);
    step("c1", 0, 0, 10'h100, 0, 0);
    step("c2", 0, 0, 10'h101, 0, 0);
    step("c3", 0, 0, 10'h051, 0, 0);

    // STACK_DEPTH+1 nested calls; the last overflows but still jumps.
    opcode = 8'h30;
    step("n0", 0, 0, 10'h200, 0, 0);
    step("n1", 0, 0, 10'h210, 0, 0);
    step("n2", 0, 0, 10'h220, 0, 0);
    step("n3", 0, 0, 10'h230, 0, 0);
    step("n4", 0, 0, 10'h240, 0, 0);
    step("n5", 0, 0, 10'h250, 0, 1);
    step("n6", 0, 0, 10'h231, 0, 1);
    step("n7", 0, 0, 10'h221, 0, 1);
    step("n8", 0, 0, 10'h211, 0, 1);
    step("n9", 0, 0, 10'h201, 0, 1);

    // Branch not taken, then taken.
    opcode = 8'h40;
    step("br0", 0, 0, 10'h060, 0, 1);
    step("br1", 0, 0, 10'h061, 0, 1);
    opcode = 8'h41;
    step("br2", 0, 0, 10'h060, 0, 1);
    step("br3", 0, 1, 10'h068, 0, 1);

    // Wait: same op for 4 cycles, then falls through.
    opcode = 8'h50;
    step("w0", 0, 0, 10'h070, 0, 1);
    step("w1", 0, 0, 10'h070, 0, 1);
    step("w2", 0, 0, 10'h070, 0, 1);
    step("w3", 0, 0, 10'h070, 0, 1);
    step("w4", 0, 1, 10'h071, 0, 1);

    // Stall during a NEXT run (mode=1 dispatch).
    mode = 1'b1; opcode = 8'h12;
    #1;
    chk("label_addr", {23'd0, label_addr}, 32'h112);
    step("s0", 0, 0, 10'h080, 0, 1);
    step("s1", 0, 0, 10'h081, 0, 1);
    step("s2", 1, 0, 10'h081, 0, 1);
    step("s3", 1, 0, 10'h081, 0, 1);
    step("s4", 0, 0, 10'h082, 0, 1);
    mode = 1'b0; opcode = 8'hFF;
    step("s5", 0, 0, 10'h083, 0, 1);

    // Invalid label, then recovery.
    step("il0", 0, 0, 10'h083, 1, 1);
    opcode = 8'h12;
    step("il1", 0, 0, 10'h040, 0, 1);
    step("il2", 0, 0, 10'h041, 0, 1);

    // Mid-program reset clears everything at once, then RET on an empty stack.
    rst_b = 1'b0; opcode = 8'h60;
    #1;
    push_zero();
    check_out("midreset");
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    step("r0", 0, 0, 10'h090, 0, 0);
    opcode = 8'h12;
    step("r1", 0, 0, 10'h040, 0, 1);
    step("r2", 0, 0, 10'h041, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
